// File: rtl/imem_loader_pkg.sv
// Shared state encoding and widths for the instruction-memory loader.
package imem_loader_pkg;

  localparam int LEN_W  = 16;
  localparam int BIDX_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and imem write-port bundles used by the loader.
interface imem_stream_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

interface imem_wr_if #(
  parameter int ADDR_W = 10
);
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wd;

  modport master (output we, output addr, output wd);
  modport slave  (input we, input addr, input wd);
endinterface

// File: rtl/imem_word_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        last
);

  logic [23:0]       sh;
  logic [BIDX_W-1:0] idx;

  // The fourth byte is not stored; the word is presented as soon as it arrives.
  assign word = {din, sh};
  assign last = (idx == BIDX_W'(3));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sh  <= '0;
      idx <= '0;
    end else if (en) begin
      sh  <= {din, sh[23:8]};
      idx <= idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: writes LE words into imem and holds the core in reset until done.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CHECKSUM_EN.
//
// state | meaning
// IDLE  | waiting for start, core held in reset
// LEN0  | expecting word-count low byte
// LEN1  | expecting word-count high byte
// DATA  | streaming image bytes into imem words
// CHK   | expecting XOR checksum byte (checksum build only)
// DONE  | image loaded, core released
// ERR   | load rejected, core held in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_stream_if.slave s,
  imem_wr_if.master    imem,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         core_rst_n
);

  state_t           state;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] wcnt;
  logic [LEN_W-1:0] len_in;
  logic             acc;
  logic             idle_like;
  logic [31:0]      word;
  logic             word_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign acc       = s.valid && s.ready;
  assign len_in    = {s.data, len_lo};
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);

  imem_word_packer u_packer (
    .clk   (clk),
    .rst   (rst),
    .clear (start && idle_like),
    .en    (acc && (state == DATA)),
    .din   (s.data),
    .word  (word),
    .last  (word_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s.ready    <= 1'b0;
      imem.we    <= 1'b0;
      imem.addr  <= '0;
      imem.wd    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
      len_lo     <= '0;
      len        <= '0;
      wcnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem.we <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          // DONE is entered one cycle before its outputs so they follow the last write.
          if (state == DONE) begin
            done       <= 1'b1;
            busy       <= 1'b0;
            core_rst_n <= 1'b1;
          end
          if (start) begin
            state      <= LEN0;
            s.ready    <= 1'b1;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            core_rst_n <= 1'b0;
            wcnt       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
          end
        end
        LEN0: begin
          if (acc) begin
            len_lo <= s.data;
            state  <= LEN1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum   <= csum ^ s.data;
`endif
          end
        end
        LEN1: begin
          if (acc) begin
            len <= len_in;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ s.data;
`endif
            if (len_in == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state      <= DONE;
              s.ready    <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
`endif
            end else if (32'(len_in) > MAX_WORDS) begin
              state   <= ERR;
              s.ready <= 1'b0;
              busy    <= 1'b0;
              err     <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ s.data;
`endif
            if (word_last) begin
              imem.we   <= 1'b1;
              imem.wd   <= word;
              imem.addr <= wcnt[ADDR_W-1:0];
              wcnt      <= wcnt + LEN_W'(1);
              if ((wcnt + LEN_W'(1)) == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                state <= CHK;
`else
                state   <= DONE;
                s.ready <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (acc) begin
            s.ready <= 1'b0;
            busy    <= 1'b0;
            if (s.data == csum) begin
              state      <= DONE;
              done       <= 1'b1;
              core_rst_n <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          state      <= ERR;
          s.ready    <= 1'b0;
          busy       <= 1'b0;
          err        <= 1'b1;
          core_rst_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte images, expected imem writes queued and
// popped by an independent write monitor.
module tb_imem_loader;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] wd;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
  logic err;
  logic core_rst_n;

  int checks = 0;
  int errors = 0;

  wr_t        exp_q[$];
  logic [7:0] bq[$];

  imem_stream_if sif ();
  imem_wr_if #(.ADDR_W(10)) wif ();

  imem_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s          (sif),
    .imem       (wif),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .core_rst_n (core_rst_n)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    if (wif.we === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0d wd=%08h required no write", wif.addr, wif.wd);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (wif.addr !== e.addr || wif.wd !== e.wd) begin
          errors++;
          $display("FAIL imem_write actual addr=%0d wd=%08h required addr=%0d wd=%08h",
                   wif.addr, wif.wd, e.addr, e.wd);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input int a, input logic [31:0] d);
    wr_t w;
    w.addr = 10'(a);
    w.wd   = d;
    exp_q.push_back(w);
  endtask

  function automatic logic [7:0] xor_q();
    logic [7:0] x = 8'h00;
    foreach (bq[i]) x ^= bq[i];
    return x;
  endfunction

  task automatic add_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    bq.push_back(xor_q());
`endif
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    sif.data  = b;
    sif.valid = 1'b1;
    while (sif.ready !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (sif.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual ready=%b required 1 within 40 cycles", sif.ready);
      sif.valid = 1'b0;
      return;
    end
    @(negedge clk);
    sif.valid = 1'b0;
  endtask

  task automatic run_bytes(input bit gappy, input bit mid_start);
    for (int i = 0; i < bq.size(); i++) begin
      if (gappy) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) @(negedge clk);
      end
      if (mid_start && i == 2) begin
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_done", 32'(done), 32'd0);
        check("mid_err", 32'(err), 32'd0);
        check("mid_core_rst_n", 32'(core_rst_n), 32'd0);
      end
      if (mid_start && i == 4) start = 1'b1;
      send_byte(bq[i]);
      start = 1'b0;
    end
  endtask

  task automatic wait_end(input string name);
    int t = 0;
    while (!(done === 1'b1 || err === 1'b1) && t < 60) begin
      @(negedge clk);
      t++;
    end
    if (!(done === 1'b1 || err === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL %s_end_timeout actual done=%b err=%b required done or err", name, done, err);
    end
  endtask

  task automatic check_status(input string name, input bit d, input bit e, input bit c);
    check({name, "_done"}, 32'(done), 32'(d));
    check({name, "_err"}, 32'(err), 32'(e));
    check({name, "_core_rst_n"}, 32'(core_rst_n), 32'(c));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_ready"}, 32'(sif.ready), 32'd0);
    check({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ready"}, 32'(sif.ready), 32'd0);
    check({name, "_we"}, 32'(wif.we), 32'd0);
    check({name, "_addr"}, 32'(wif.addr), 32'd0);
    check({name, "_wd"}, wif.wd, 32'd0);
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_err"}, 32'(err), 32'd0);
    check({name, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
  endtask

  task automatic load_two_words(input string name);
    pulse_start();
    bq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h02, 8'h50, 8'h00};
    add_csum();
    expect_wr(0, 32'h0000_0013);
    expect_wr(1, 32'h0050_0293);
    run_bytes(1'b0, 1'b0);
    wait_end(name);
    check_status(name, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    sif.valid = 1'b0;
    sif.data  = 8'h00;
    start     = 1'b0;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // two-word program, back-to-back bytes
    load_two_words("n2");

    // empty image
    pulse_start();
    bq = '{8'h00, 8'h00};
    add_csum();
    run_bytes(1'b0, 1'b0);
    wait_end("n0");
    check_status("n0", 1'b1, 1'b0, 1'b1);

    // one word beyond the limit
    pulse_start();
    bq = '{8'h01, 8'h04};
    run_bytes(1'b0, 1'b0);
    wait_end("over");
    check_status("over", 1'b0, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    bq = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'h72};
    expect_wr(0, 32'h0000_0073);
    run_bytes(1'b0, 1'b0);
    wait_end("csum_ok");
    check_status("csum_ok", 1'b1, 1'b0, 1'b1);

    pulse_start();
    bq = '{8'h01, 8'h00, 8'h73, 8'h00, 8'h00, 8'h00, 8'h00};
    expect_wr(0, 32'h0000_0073);
    run_bytes(1'b0, 1'b0);
    wait_end("csum_bad");
    check_status("csum_bad", 1'b0, 1'b1, 1'b0);
`endif

    // gappy stream with a start pulse while busy
    pulse_start();
    bq = '{8'h03, 8'h00,
           8'h44, 8'h33, 8'h22, 8'h11,
           8'hEF, 8'hBE, 8'hAD, 8'hDE,
           8'h01, 8'h00, 8'h00, 8'h00};
    add_csum();
    expect_wr(0, 32'h1122_3344);
    expect_wr(1, 32'hDEAD_BEEF);
    expect_wr(2, 32'h0000_0001);
    run_bytes(1'b1, 1'b1);
    wait_end("gappy");
    check_status("gappy", 1'b1, 1'b0, 1'b1);

    // reset partway into a four-word image
    pulse_start();
    bq = '{8'h04, 8'h00,
           8'hDD, 8'hCC, 8'hBB, 8'hAA,
           8'h04, 8'h03, 8'h02, 8'h01,
           8'h55};
    expect_wr(0, 32'hAABB_CCDD);
    expect_wr(1, 32'h0102_0304);
    run_bytes(1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_writes_left", 32'(exp_q.size()), 32'd0);
    check("midrst_idle_busy", 32'(busy), 32'd0);

    load_two_words("reload");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
